gpio_reset_debouncer: RTL

- Sits directly upstream of the SoC top on the Gowin board.
- Takes the raw active-low reset push-button (gpio_in[0]), synchronises and debounces it, and adds a power-on reset stretch.
- Drives the SoC's active-high synchronous reset input with a clean, minimum-width pulse.
- Also exposes the debounced button level, a press strobe and a saturating count of button-initiated resets for LED/debug use.

---
 rtl/gpio_reset_debouncer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/gpio_reset_debouncer.sv
// rtl/gpio_reset_debouncer.sv - push-button reset synchroniser, debouncer and SoC reset sequencer
// Turns the raw active-low button into a clean, minimum-width active-high SoC reset.

module gpio_reset_debouncer #(
   parameter int SYNC_STAGES       = 2,
   parameter int DEBOUNCE_CYCLES   = 1000000,
   parameter int RESET_HOLD_CYCLES = 16,
   parameter int POR_CYCLES        = 64
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       btn_raw,
   output logic       soc_reset,
   output logic       btn_level,
   output logic       press_pulse,
   output logic [7:0] reset_count
);

   localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_MAX = (POR_CYCLES > RESET_HOLD_CYCLES) ? POR_CYCLES : RESET_HOLD_CYCLES;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_POR  = HOLD_W'(POR_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_BTN  = HOLD_W'(RESET_HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_POR,
      ST_RUN,
      ST_ASSERT,
      ST_WAIT_RELEASE
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_s;
   logic [CNT_W-1:0]       db_cnt;
   logic                   commit;
   logic                   fall;
   logic                   rise;
   logic                   level_next;
   state_t                 state;
   logic [HOLD_W-1:0]      hold;

   // Plain flop chain; the last stage is the only one the logic looks at.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      end
   end

   assign sync_s     = sync_q[SYNC_STAGES-1];
   assign commit     = (sync_s != btn_level) && (db_cnt == CNT_LAST);
   assign fall       = commit && btn_level;
   assign rise       = commit && !btn_level;
   assign level_next = commit ? sync_s : btn_level;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         db_cnt    <= '0;
         btn_level <= 1'b1;
      end else if (sync_s == btn_level) begin
         db_cnt <= '0;
      end else if (commit) begin
         db_cnt    <= '0;
         btn_level <= sync_s;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   // Hold-expiry exits look at level_next so a press committed on the exit
   // edge itself still lands in WAIT_RELEASE instead of slipping into RUN.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_POR;
         hold        <= HOLD_POR;
         soc_reset   <= 1'b1;
         press_pulse <= 1'b0;
         reset_count <= 8'd0;
      end else begin
         press_pulse <= 1'b0;
         case (state)
            ST_POR, ST_ASSERT: begin
               if (hold == '0) begin
                  if (!level_next) begin
                     state     <= ST_WAIT_RELEASE;
                     soc_reset <= 1'b1;
                  end else begin
                     state     <= ST_RUN;
                     soc_reset <= 1'b0;
                  end
               end else begin
                  hold      <= hold - 1'b1;
                  soc_reset <= 1'b1;
               end
            end
            ST_RUN: begin
               if (fall) begin
                  state       <= ST_ASSERT;
                  hold        <= HOLD_BTN;
                  soc_reset   <= 1'b1;
                  press_pulse <= 1'b1;
                  if (reset_count != 8'hFF) begin
                     reset_count <= reset_count + 8'd1;
                  end
               end else begin
                  soc_reset <= 1'b0;
               end
            end
            ST_WAIT_RELEASE: begin
               if (rise) begin
                  state     <= ST_RUN;
                  soc_reset <= 1'b0;
               end else begin
                  soc_reset <= 1'b1;
               end
            end
            default: begin
               state     <= ST_POR;
               hold      <= HOLD_POR;
               soc_reset <= 1'b1;
            end
         endcase
      end
   end

endmodule
